uart_rx_fifo: RTL and testbench

Parametrised UART receiver: a second-generation AHB-lite slave peripheral for the SoC bus. It adds the following over the first-generation receiver:
- runtime baud divisor
- selectable data width, parity mode and stop-bit count
- input synchroniser with false-start rejection
- receive FIFO
- sticky error flags (parity/framing/overrun)
- maskable level interrupt

---
 rtl/uart_rx_fifo_pkg.sv | 56 +++++
 rtl/uart_rx_fifo_sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the AHB-lite UART receiver: bus encodings, register map,
// control/status bit positions and receive FSM states.
package uart_rx_fifo_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [1:0] UART_RX_REG_RXDATA = 2'd0;
    localparam logic [1:0] UART_RX_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_RX_REG_CTRL   = 2'd2;
    localparam logic [1:0] UART_RX_REG_BAUD   = 2'd3;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_PERR      = 2;
    localparam int ST_FERR      = 3;
    localparam int ST_OVR       = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CT_EN       = 0;
    localparam int CT_PAR_LSB  = 1;
    localparam int CT_STOP2    = 3;
    localparam int CT_DLEN_LSB = 4;
    localparam int CT_RXIE     = 8;
    localparam int CT_ERRIE    = 9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // DLEN values outside 5..max_w (including the reset value 0) mean full width.
    function automatic logic [3:0] eff_dlen(input logic [3:0] dlen, input int max_w);
        return (dlen < 4'd5 || int'(dlen) > max_w) ? 4'(max_w) : dlen;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; pointers carry one
// extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_rx_fifo.sv
// AHB-lite UART receiver: synchronised RX line, configurable frame format,
// receive FIFO, sticky error flags and a maskable level interrupt.
import uart_rx_fifo_pkg::*;

module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 434,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel_rx,
    input  logic [WORD_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [WORD_WIDTH-1:0] HWDATA,
    input  logic                  RX,
    output logic [WORD_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [1:0]            HRESP,
    output logic                  irq_uartRx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);

    logic [9:0]            ctrl;
    logic [DIV_WIDTH-1:0]  baud;
    logic                  perr_flag, ferr_flag, ovr_flag;
    logic                  ap_valid, ap_write;
    logic [1:0]            ap_addr;
    logic                  rx_meta, rxs, rxs_prev;
    rx_state_e             state, state_next;
    logic [DIV_WIDTH-1:0]  cnt, div_cur;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_acc, stop_bad;
    logic                  tick, commit, fall;
    logic                  en, stop2, par_on, par_bad, frame_bad;
    parity_e               par_mode;
    logic [3:0]            dlen;
    logic                  addr_rd, wr_en, w1c;
    logic [WORD_WIDTH-1:0] rd_mux, status_word;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata, frame_data;
    logic [CW-1:0]         fifo_count;
    logic                  unused_ok;

    assign unused_ok = ^{HSIZE, HADDR[WORD_WIDTH-1:4], HADDR[1:0], HWDATA[WORD_WIDTH-1:16]};

    assign HREADY = 1'b1;
    assign HRESP  = HRESP_OKAY;

    assign en       = ctrl[CT_EN];
    assign stop2    = ctrl[CT_STOP2];
    assign par_mode = parity_e'(ctrl[CT_PAR_LSB +: 2]);
    assign par_on   = (par_mode == PAR_ODD) || (par_mode == PAR_EVEN);
    assign dlen     = eff_dlen(ctrl[CT_DLEN_LSB +: 4], DATA_WIDTH);

    assign addr_rd  = hsel_rx && (HTRANS == HTRANS_NONSEQ) && !HWRITE;
    assign fifo_pop = addr_rd && (HADDR[3:2] == UART_RX_REG_RXDATA) && !fifo_empty;
    assign wr_en    = ap_valid && ap_write;
    assign w1c      = wr_en && (ap_addr == UART_RX_REG_STATUS);

    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_PERR]  = perr_flag;
        status_word[ST_FERR]  = ferr_flag;
        status_word[ST_OVR]   = ovr_flag;
        status_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        rd_mux = '0;
        case (HADDR[3:2])
            UART_RX_REG_RXDATA: rd_mux = fifo_empty ? '0 : WORD_WIDTH'(fifo_rdata);
            UART_RX_REG_STATUS: rd_mux = status_word;
            UART_RX_REG_CTRL:   rd_mux = WORD_WIDTH'(ctrl);
            UART_RX_REG_BAUD:   rd_mux = WORD_WIDTH'(baud);
            default:            rd_mux = '0;
        endcase
    end

    // Read data is captured at the address phase; writes land in the data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_addr  <= '0;
            HRDATA   <= '0;
            ctrl     <= '0;
            baud     <= DIV_WIDTH'(DIV_RESET);
        end else begin
            ap_valid <= hsel_rx && (HTRANS == HTRANS_NONSEQ);
            ap_write <= HWRITE;
            ap_addr  <= HADDR[3:2];
            HRDATA   <= addr_rd ? rd_mux : '0;
            if (wr_en && ap_addr == UART_RX_REG_CTRL) ctrl <= HWDATA[9:0];
            if (wr_en && ap_addr == UART_RX_REG_BAUD)
                baud <= (HWDATA[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : HWDATA[DIV_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= RX;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign fall = rxs_prev && !rxs;
    assign tick = (state == RX_START) ? (cnt == (div_cur >> 1) - DIV_ONE)
                                      : (cnt == div_cur - DIV_ONE);

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        if (!en) begin
            state_next = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE:   if (fall) state_next = RX_START;
                RX_START:  if (tick) state_next = rxs ? RX_IDLE : RX_DATA;
                RX_DATA:   if (tick && bit_idx == dlen - 4'd1)
                               state_next = par_on ? RX_PARITY : RX_STOP;
                RX_PARITY: if (tick) state_next = RX_STOP;
                RX_STOP:   if (tick && (!stop2 || bit_idx == 4'd1)) begin
                               state_next = RX_IDLE;
                               commit     = 1'b1;
                           end
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    // BAUD is reloaded into div_cur only at bit boundaries so a mid-bit write cannot stretch the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_cur  <= DIV_WIDTH'(DIV_RESET);
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == RX_IDLE) begin
            cnt      <= '0;
            div_cur  <= baud;
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (tick) begin
            cnt     <= '0;
            div_cur <= baud;
            case (state)
                RX_DATA: begin
                    shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
                    par_acc <= par_acc ^ rxs;
                    bit_idx <= (bit_idx == dlen - 4'd1) ? 4'd0 : bit_idx + 4'd1;
                end
                RX_PARITY: par_acc <= par_acc ^ rxs;
                RX_STOP: begin
                    stop_bad <= stop_bad | !rxs;
                    bit_idx  <= bit_idx + 4'd1;
                end
                default: bit_idx <= '0;
            endcase
        end else begin
            cnt <= cnt + DIV_ONE;
        end
    end

    assign frame_data = shreg >> (4'(DATA_WIDTH) - dlen);
    assign par_bad    = par_on && ((par_mode == PAR_ODD) ? !par_acc : par_acc);
    assign frame_bad  = stop_bad || !rxs;
    assign fifo_push  = commit && !fifo_full;

    // A set from a committing frame wins over a simultaneous W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_flag  <= 1'b0;
            ferr_flag  <= 1'b0;
            ovr_flag   <= 1'b0;
            irq_uartRx <= 1'b0;
        end else begin
            perr_flag  <= (perr_flag && !(w1c && HWDATA[ST_PERR])) || (commit && par_bad);
            ferr_flag  <= (ferr_flag && !(w1c && HWDATA[ST_FERR])) || (commit && frame_bad);
            ovr_flag   <= (ovr_flag  && !(w1c && HWDATA[ST_OVR]))  || (commit && fifo_full);
            irq_uartRx <= (ctrl[CT_RXIE] && !fifo_empty) ||
                          (ctrl[CT_ERRIE] && (perr_flag || ferr_flag || ovr_flag));
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (frame_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frame vectors, hand-written
// corner sequences and randomized frames against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int BAUD_CYC = 16;
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst, hsel_rx, hwrite, rx;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans, hresp;
    logic        hready, irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [8:0] model_q[$];
    bit         m_perr, m_ferr, m_ovr;

    typedef struct {
        logic [8:0]  data;
        int          dlen;
        logic [1:0]  par;
        bit          stop2;
        bit          bad_par;
        bit          bad_stop;
        logic [31:0] exp_data;
        bit          exp_perr;
        bit          exp_ferr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .hsel_rx    (hsel_rx),
        .HADDR      (haddr),
        .HWRITE     (hwrite),
        .HSIZE      (hsize),
        .HTRANS     (htrans),
        .HWDATA     (hwdata),
        .RX         (rx),
        .HRDATA     (hrdata),
        .HREADY     (hready),
        .HRESP      (hresp),
        .irq_uartRx (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        hsel_rx = 1'b1; haddr = a; hwrite = 1'b1; htrans = 2'b10;
        @(negedge clk);
        hsel_rx = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(negedge clk);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        hsel_rx = 1'b1; haddr = a; hwrite = 1'b0; htrans = 2'b10;
        @(negedge clk);
        hsel_rx = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    function automatic logic [31:0] ctrl_word(input bit en, input logic [1:0] par, input bit stop2,
                                              input int dlen, input bit rxie, input bit errie);
        return {22'd0, errie, rxie, 4'(dlen), stop2, par, en};
    endfunction

    function automatic logic [31:0] exp_status();
        int n;
        n = model_q.size();
        return {16'd0, 8'(n), 3'd0, m_ovr, m_ferr, m_perr, (n == DEPTH), (n == 0)};
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BAUD_CYC) @(negedge clk);
    endtask

    // Serial frame: start, dlen data bits LSB first, optional parity, 1 or 2 stops, one idle bit.
    task automatic send_frame(input logic [8:0] data, input int dlen, input logic [1:0] par,
                              input bit stop2, input bit bad_par, input bit bad_stop);
        logic [8:0] d;
        logic       p;
        d = data & 9'((1 << dlen) - 1);
        drive_bit(1'b0);
        for (int i = 0; i < dlen; i++) drive_bit(d[i]);
        if (par == 2'b01 || par == 2'b10) begin
            p = (par == 2'b01) ? ~^d : ^d;
            drive_bit(p ^ bad_par);
        end
        if (stop2) drive_bit(1'b1);
        drive_bit(!bad_stop);
        drive_bit(1'b1);
    endtask

    task automatic tx(input logic [8:0] data, input int dlen, input logic [1:0] par,
                      input bit stop2, input bit bad_par, input bit bad_stop);
        send_frame(data, dlen, par, stop2, bad_par, bad_stop);
        if (bad_par && (par == 2'b01 || par == 2'b10)) m_perr = 1'b1;
        if (bad_stop) m_ferr = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(data & 9'((1 << dlen) - 1));
        else m_ovr = 1'b1;
    endtask

    task automatic check_status(input string name);
        logic [31:0] v;
        ahb_read(32'h4, v);
        checkOutput(name, v, exp_status());
    endtask

    task automatic drain(input string name);
        logic [31:0] v;
        while (model_q.size() > 0) begin
            ahb_read(32'h0, v);
            checkOutput(name, v, 32'(model_q.pop_front()));
        end
        ahb_read(32'h0, v);
        checkOutput({name, "_empty_read"}, v, 32'h0);
        check_status({name, "_status_after"});
    endtask

    task automatic clear_flags();
        ahb_write(32'h4, 32'h1C);
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] r;
        ahb_write(32'h8, ctrl_word(1'b1, v.par, v.stop2, v.dlen, 1'b0, 1'b0));
        send_frame(v.data, v.dlen, v.par, v.stop2, v.bad_par, v.bad_stop);
        ahb_read(32'h4, r);
        checkOutput($sformatf("vec%0d_status", idx), r,
                    32'h100 | (32'(v.exp_perr) << 2) | (32'(v.exp_ferr) << 3));
        ahb_read(32'h0, r);
        checkOutput($sformatf("vec%0d_data", idx), r, v.exp_data);
        ahb_write(32'h4, 32'h1C);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; hsel_rx = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'b010;
        htrans = 2'b00; hwdata = '0; rx = 1'b1;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_hrdata", hrdata, 32'h0);
        checkOutput("reset_hready", 32'(hready), 32'h1);
        checkOutput("reset_hresp", 32'(hresp), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        check_status("reset_status");
        ahb_read(32'h8, r); checkOutput("reset_ctrl", r, 32'h0);
        ahb_read(32'hC, r); checkOutput("reset_baud", r, 32'd434);
        ahb_write(32'hC, 32'd2);
        ahb_read(32'hC, r); checkOutput("baud_clamp", r, 32'd4);
        ahb_write(32'hC, BAUD_CYC);
        ahb_read(32'hC, r); checkOutput("baud_write", r, 32'(BAUD_CYC));

        vecs[0] = '{9'h0A5, 8, 2'b01, 1'b0, 1'b0, 1'b0, 32'hA5, 1'b0, 1'b0};
        vecs[1] = '{9'h03C, 8, 2'b01, 1'b0, 1'b1, 1'b0, 32'h3C, 1'b1, 1'b0};
        vecs[2] = '{9'h07F, 7, 2'b00, 1'b1, 1'b0, 1'b0, 32'h7F, 1'b0, 1'b0};
        vecs[3] = '{9'h055, 7, 2'b11, 1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1};
        vecs[4] = '{9'h1F3, 5, 2'b10, 1'b0, 1'b0, 1'b0, 32'h13, 1'b0, 1'b0};
        vecs[5] = '{9'h00F, 8, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0F, 1'b0, 1'b1};
        vecs[6] = '{9'h0C3, 6, 2'b10, 1'b0, 1'b1, 1'b0, 32'h03, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Error interrupt held until W1C of parity_err.
        ahb_write(32'h8, ctrl_word(1'b1, 2'b01, 1'b0, 8, 1'b0, 1'b1));
        tx(9'h03C, 8, 2'b01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("irq_err_set", 32'(irq), 32'h1);
        check_status("irq_err_status");
        ahb_write(32'h4, 32'h04);
        m_perr = 1'b0;
        @(negedge clk);
        checkOutput("irq_err_w1c", 32'(irq), 32'h0);
        drain("irq_err_data");

        // Data interrupt clears on pop.
        ahb_write(32'h8, ctrl_word(1'b1, 2'b00, 1'b0, 8, 1'b1, 1'b0));
        tx(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("irq_rx_set", 32'(irq), 32'h1);
        ahb_read(32'h0, r);
        checkOutput("irq_rx_data", r, 32'(model_q.pop_front()));
        @(negedge clk);
        checkOutput("irq_rx_pop", 32'(irq), 32'h0);

        // Overrun: 17 frames into a 16-deep FIFO.
        ahb_write(32'h8, ctrl_word(1'b1, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        for (int i = 0; i < 17; i++) tx(9'((i * 7 + 1) & 8'hFF), 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check_status("overrun_status");
        checkOutput("overrun_first", 32'(model_q[0]), 32'h1);
        drain("overrun_data");
        clear_flags();

        // False start: short low glitch must leave no trace, then a real frame is received.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_status("glitch_status");
        tx(9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        drain("glitch_next_frame");

        // EN cleared mid-frame: partial frame dropped, FIFO retained.
        tx(9'h021, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(9'h0E7, 8, 2'b00, 1'b0, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                ahb_write(32'h8, ctrl_word(1'b0, 2'b00, 1'b0, 8, 1'b0, 1'b0));
            end
        join
        ahb_write(32'h8, ctrl_word(1'b1, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        repeat (20) @(negedge clk);
        check_status("abort_status");
        drain("abort_data");

        // Randomized rounds against the reference model.
        for (int rnd = 0; rnd < 5; rnd++) begin
            int         dl, nf;
            logic [1:0] pm;
            bit         s2;
            dl = $urandom_range(5, 8);
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            nf = $urandom_range(1, 5);
            ahb_write(32'h8, ctrl_word(1'b1, pm, s2, dl, 1'b0, 1'b0));
            for (int f = 0; f < nf; f++)
                tx(9'($urandom), dl, pm, s2, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            check_status($sformatf("rand%0d_status", rnd));
            drain($sformatf("rand%0d_data", rnd));
            clear_flags();
        end

        // Reset mid-frame with five entries queued.
        ahb_write(32'h8, ctrl_word(1'b1, 2'b00, 1'b0, 8, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) tx(9'(8'h40 + i), 8, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_irq", 32'(irq), 32'h1);
        fork
            send_frame(9'h099, 8, 2'b00, 1'b0, 1'b0, 1'b0);
            begin
                repeat (50) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("midrst_hrdata", hrdata, 32'h0);
                checkOutput("midrst_irq", 32'(irq), 32'h0);
                checkOutput("midrst_hready", 32'(hready), 32'h1);
                checkOutput("midrst_hresp", 32'(hresp), 32'h0);
                model_q.delete();
                m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
                check_status("midrst_status");
                ahb_read(32'hC, r); checkOutput("midrst_baud", r, 32'd434);
                ahb_read(32'h8, r); checkOutput("midrst_ctrl", r, 32'h0);
            end
        join
        repeat (20) @(negedge clk);
        check_status("post_reset_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
